// File: rtl/sap_cpu_param.sv
`default_nettype none
// ============================================================================
// Module   : sap_cpu_param
// Purpose  : Parametrised SAP-style accumulator CPU with internal RAM.
//            A single shared RAM port is used for program loading (IDLE only),
//            instruction/operand fetch and STA writes. Instructions take
//            4, 5 or 6 T-states and return to T1 (run=1) or IDLE (run=0).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   run               1 = execute, 0 = stop at the next instruction boundary
//   prog_we/addr/data RAM load port, honoured only in IDLE
//   out_data/valid    OUT register and its one-cycle update strobe
//   halted            high while in HALT
//   acc, pc, flags    architectural state, flags = {C,Z}
//   state             0 IDLE, 1..6 T1..T6, 7 HALT
// ============================================================================
module sap_cpu_param #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          halted,
  output logic [DW-1:0] acc,
  output logic [AW-1:0] pc,
  output logic [1:0]    flags,
  output logic [2:0]    state
);

  localparam int OPW   = DW - AW;
  localparam int DEPTH = 1 << AW;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JC  = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd7;
  localparam logic [3:0] OP_NOP = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  generate
    if (OPW < 4) begin : g_opw_check
      $error("sap_cpu_param: opcode field DW-AW must be at least 4 bits");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] b_q, b_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          c_q, c_d;
  logic          z_q, z_d;
  logic [DW-1:0] out_q, out_d;
  logic          outv_q, outv_d;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_rd;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  logic [3:0]    op;
  logic [AW-1:0] operand;
  logic [DW:0]   sum;
  logic [DW-1:0] diff;
  state_t        end_state;

  assign operand = ir_q[AW-1:0];

  // Wide opcode fields decode as NOP whenever any bit above the low four is set.
  generate
    if (OPW > 4) begin : g_op_wide
      assign op = (ir_q[DW-1:AW+4] == '0) ? ir_q[AW+3:AW] : OP_NOP;
    end else begin : g_op_narrow
      assign op = ir_q[AW+3:AW];
    end
  endgenerate

  assign sum       = {1'b0, acc_q} + {1'b0, b_q};
  assign diff      = acc_q - b_q;
  assign end_state = run ? S_T1 : S_IDLE;
  assign ram_rd    = mem[mar_q];

  // The single RAM port: loader in IDLE, STA in T5; reads only in T3/T5.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = prog_addr;
    ram_wdata = prog_data;
    if (state_q == S_IDLE && prog_we) begin
      ram_we = 1'b1;
    end else if (state_q == S_T5 && op == OP_STA) begin
      ram_we    = 1'b1;
      ram_waddr = mar_q;
      ram_wdata = acc_q;
    end
  end

  // RAM is deliberately outside the reset domain so a program survives rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    out_d   = out_q;
    outv_d  = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T1;
      S_T1: begin
        mar_d   = pc_q;
        state_d = S_T2;
      end
      S_T2: begin
        pc_d    = pc_q + AW'(1);
        state_d = S_T3;
      end
      S_T3: begin
        ir_d    = ram_rd;
        state_d = S_T4;
      end
      S_T4: begin
        state_d = end_state;
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_d   = operand;
            state_d = S_T5;
          end
          OP_LDI: acc_d = {{OPW{1'b0}}, operand};
          OP_JMP: pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_OUT: begin
            out_d  = acc_q;
            outv_d = 1'b1;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_T5: begin
        state_d = end_state;
        case (op)
          OP_LDA: acc_d = ram_rd;
          OP_ADD, OP_SUB: begin
            b_d     = ram_rd;
            state_d = S_T6;
          end
          default: ;
        endcase
      end
      S_T6: begin
        state_d = end_state;
        if (op == OP_ADD) begin
          acc_d = sum[DW-1:0];
          c_d   = sum[DW];
          z_d   = (sum[DW-1:0] == '0);
        end else begin
          acc_d = diff;
          c_d   = (acc_q >= b_q);   // C means "no borrow" for SUB
          z_d   = (diff == '0);
        end
      end
      S_HALT: if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= '0;
      outv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
      out_q   <= out_d;
      outv_q  <= outv_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = outv_q;
  assign halted    = (state_q == S_HALT);
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign flags     = {c_q, z_q};
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sap_cpu_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap_cpu_param
// Purpose  : Self-checking bench for sap_cpu_param. An instruction-level
//            reference model runs in lockstep with the DUT and is compared at
//            every instruction boundary; directed programs plus random ones.
// Revision : 1.0  initial release
// ============================================================================
module tb_sap_cpu_param;

  logic       clk = 1'b0;
  logic       rst, run, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data, out_data, acc;
  logic       out_valid, halted;
  logic [3:0] pc;
  logic [1:0] flags;
  logic [2:0] state;

  logic        run12, we12, outv12, halt12;
  logic [5:0]  addr12, pc12;
  logic [11:0] data12, out12, acc12;
  logic [1:0]  flags12;
  logic [2:0]  state12;

  always #5 clk = ~clk;

  sap_cpu_param #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .out_data(out_data), .out_valid(out_valid),
    .halted(halted), .acc(acc), .pc(pc), .flags(flags), .state(state)
  );

  sap_cpu_param #(.DW(12), .AW(6)) dut12 (
    .clk(clk), .rst(rst), .run(run12), .prog_we(we12), .prog_addr(addr12),
    .prog_data(data12), .out_data(out12), .out_valid(outv12),
    .halted(halt12), .acc(acc12), .pc(pc12), .flags(flags12), .state(state12)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_cycles;

  always @(posedge clk) cyc++;

  logic [7:0] obs_out[$];
  always @(negedge clk) if (out_valid === 1'b1) obs_out.push_back(out_data);

  // ---------------- instruction-level reference model ----------------
  logic [7:0] m_mem [16];
  logic [7:0] m_acc, m_last_out;
  logic [3:0] m_pc, m_pcinc;
  logic       m_c, m_z, m_halt, m_fire;
  int         m_len;
  logic [7:0] m_outs[$];
  logic [7:0] p [16];
  logic [11:0] p12 [64];

  task automatic m_reset();
    m_acc = 0; m_pc = 0; m_c = 0; m_z = 0; m_halt = 0; m_fire = 0;
  endtask

  task automatic m_step();
    logic [7:0] ins;
    int opc, opr, s;
    ins = m_mem[m_pc];
    opc = int'(ins) / 16;
    opr = int'(ins) % 16;
    m_pc = m_pc + 4'd1;
    m_pcinc = m_pc;
    m_len = 4;
    m_fire = 0;
    case (opc)
      0: begin m_acc = m_mem[opr]; m_len = 5; end
      1: begin
        s = int'(m_acc) + int'(m_mem[opr]);
        m_c = (s > 255); m_acc = s[7:0]; m_z = (m_acc == 0); m_len = 6;
      end
      2: begin
        m_c = (m_acc >= m_mem[opr]);
        m_acc = m_acc - m_mem[opr]; m_z = (m_acc == 0); m_len = 6;
      end
      3: begin m_mem[opr] = m_acc; m_len = 5; end
      4: m_acc = 8'(opr);
      5: m_pc = 4'(opr);
      6: if (m_c) m_pc = 4'(opr);
      7: if (m_z) m_pc = 4'(opr);
      14: begin m_fire = 1; m_last_out = m_acc; m_outs.push_back(m_acc); end
      15: m_halt = 1;
      default: ;
    endcase
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input logic [2:0] s, input int pcv, input string tag);
    int k;
    k = 0;
    while (k < 60 && !(state === s && (pcv < 0 || pc === pcv[3:0]))) begin
      @(negedge clk);
      k++;
    end
    chk(tag, state, s);
    if (pcv >= 0) chk({tag, "_pc"}, pc, pcv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; run = 0; prog_we = 0;
    @(negedge clk);
    rst = 0;
    m_reset();
  endtask

  task automatic load_word(input int a, input logic [7:0] d);
    prog_we = 1; prog_addr = 4'(a); prog_data = d;
    m_mem[a] = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic load_buf();
    for (int a = 0; a < 16; a++) load_word(a, p[a]);
  endtask

  task automatic clear_buf();
    for (int a = 0; a < 16; a++) p[a] = 8'h00;
  endtask

  task automatic check_bnd(input string tag);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_acc"}, acc, m_acc);
    chk({tag, "_flags"}, flags, {m_c, m_z});
  endtask

  // Runs up to n instructions in lockstep; run is dropped during the n-th.
  task automatic exec(input int n, input bit noise);
    int t0;
    m_fire = 0;
    obs_out.delete();
    m_outs.delete();
    @(negedge clk);
    run = 1;
    wait_for(3'd1, -1, "start_T1");
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      check_bnd("bnd");
      chk("bnd_outv", out_valid, m_fire);
      if (m_fire) chk("bnd_out", out_data, m_last_out);
      if (i == n - 1) run = 0;
      m_step();
      for (int k = 1; k <= m_len; k++) begin
        if (noise) begin
          prog_we = 1; prog_addr = 4'($urandom); prog_data = 8'($urandom);
        end
        @(negedge clk);
        if (k == 2) chk("pc_inc", pc, m_pcinc);
      end
      prog_we = 0;
      if (m_halt) begin
        last_cycles = cyc - t0;
        chk("halt_state", state, 3'd7);
        chk("halted", halted, 1'b1);
        check_bnd("halt");
        break;
      end
      if (!run) begin
        chk("stop_state", state, 3'd0);
        check_bnd("stop");
        break;
      end
      chk("bnd_state", state, 3'd1);
    end
    chk("out_count", obs_out.size(), m_outs.size());
    for (int j = 0; j < m_outs.size() && j < obs_out.size(); j++)
      chk("out_seq", obs_out[j], m_outs[j]);
  endtask

  task automatic leave_halt();
    if (state === 3'd7) begin
      @(negedge clk);
      run = 0;
      wait_for(3'd0, -1, "leave_halt");
      chk("halted_clear", halted, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1; run = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    run12 = 0; we12 = 0; addr12 = 0; data12 = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_acc", acc, 8'h00);
    chk("rst_pc", pc, 4'h0);
    chk("rst_flags", flags, 2'b00);
    chk("rst_out", out_data, 8'h00);
    chk("rst_outv", out_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    rst = 0;
    m_reset();

    // DW=12 / AW=6: JMP to 0x3E, pc wraps past 0x3F, wide-opcode NOP, ADD overflow.
    for (int a = 0; a < 64; a++) p12[a] = 12'h000;
    p12[0] = 12'h17E; p12[6'h3E] = 12'h020; p12[6'h3F] = 12'h141;
    p12[1] = 12'h061; p12[2] = 12'hBC0;     p12[3] = 12'h3C0;
    p12[6'h20] = 12'hFFF; p12[6'h21] = 12'h001;
    for (int a = 0; a < 64; a++) begin
      we12 = 1; addr12 = 6'(a); data12 = p12[a];
      @(negedge clk);
    end
    we12 = 0;
    run12 = 1;
    k = 0;
    while (k < 300 && halt12 !== 1'b1) begin @(negedge clk); k++; end
    chk("w12_halted", halt12, 1'b1);
    chk("w12_acc", acc12, 12'h000);
    chk("w12_flags", flags12, 2'b11);
    chk("w12_pc", pc12, 6'd4);
    run12 = 0;

    // Basic program: LDA 9, ADD A, OUT, HLT.
    do_reset();
    clear_buf();
    p[0] = 8'h09; p[1] = 8'h1A; p[2] = 8'hE0; p[3] = 8'hF0; p[9] = 8'h10; p[10] = 8'h14;
    load_buf();
    exec(50, 0);
    chk("basic_cycles", last_cycles, 19);
    chk("basic_pulses", obs_out.size(), 1);
    chk("basic_out", obs_out[0], 8'h24);
    chk("basic_acc", acc, 8'h24);
    chk("basic_flags", flags, 2'b00);
    leave_halt();

    // Flag cases: {op, a, b, expected acc, expected flags}.
    for (int t = 0; t < 3; t++) begin
      logic [7:0] va, vb, ex;
      logic [1:0] ef;
      logic [7:0] ins;
      case (t)
        0: begin ins = 8'h1F; va = 8'hF0; vb = 8'h20; ex = 8'h10; ef = 2'b10; end
        1: begin ins = 8'h2F; va = 8'h10; vb = 8'h10; ex = 8'h00; ef = 2'b11; end
        default: begin ins = 8'h2F; va = 8'h05; vb = 8'h07; ex = 8'hFE; ef = 2'b00; end
      endcase
      do_reset();
      clear_buf();
      p[0] = 8'h0E; p[1] = ins; p[2] = 8'hF0; p[14] = va; p[15] = vb;
      load_buf();
      exec(20, 0);
      chk("flag_acc", acc, ex);
      chk("flag_cz", flags, ef);
      leave_halt();
    end

    // Countdown loop: SUB 1, OUT, JZ -> HLT, NOP, JMP at 0xF back to the body.
    do_reset();
    clear_buf();
    p[0] = 8'h43; p[1] = 8'h5B; p[2] = 8'hF0; p[10] = 8'h01;
    p[11] = 8'h2A; p[12] = 8'hE0; p[13] = 8'h72; p[14] = 8'h80; p[15] = 8'h5B;
    load_buf();
    exec(60, 0);
    chk("loop_n", obs_out.size(), 3);
    chk("loop_o0", obs_out[0], 8'h02);
    chk("loop_o1", obs_out[1], 8'h01);
    chk("loop_o2", obs_out[2], 8'h00);
    chk("loop_halt_pc", pc, 4'h3);
    leave_halt();

    // STA/LDI with load-port noise while running, then readback from IDLE.
    do_reset();
    clear_buf();
    p[0] = 8'h45; p[1] = 8'h3C; p[2] = 8'h0C; p[3] = 8'hE0; p[4] = 8'hF0;
    load_buf();
    exec(20, 1);
    chk("sta_out", obs_out[0], 8'h05);
    leave_halt();
    do_reset();
    load_word(0, 8'h0C); load_word(1, 8'hE0); load_word(2, 8'h04); load_word(3, 8'hE0);
    exec(20, 0);
    chk("rb_c", obs_out[0], 8'h05);
    chk("rb_4", obs_out[1], 8'hF0);
    leave_halt();

    // run dropped during T5 of ADD: ADD completes, core idles with pc held.
    do_reset();
    clear_buf();
    p[0] = 8'h0E; p[1] = 8'h1F; p[2] = 8'hE0; p[3] = 8'hF0; p[14] = 8'h30; p[15] = 8'h04;
    load_buf();
    @(negedge clk);
    run = 1;
    wait_for(3'd5, 2, "pause_T5");
    run = 0;
    @(negedge clk);
    chk("pause_T6", state, 3'd6);
    @(negedge clk);
    chk("pause_idle", state, 3'd0);
    chk("pause_acc", acc, 8'h34);
    chk("pause_pc", pc, 4'h2);
    repeat (3) @(negedge clk);
    chk("pause_hold", state, 3'd0);
    m_step();
    m_step();
    exec(10, 0);
    chk("resume_out", obs_out[0], 8'h34);
    leave_halt();

    // Asynchronous reset in T4 of OUT.
    do_reset();
    clear_buf();
    p[0] = 8'h45; p[1] = 8'hE0; p[2] = 8'hF0;
    load_buf();
    @(negedge clk);
    run = 1;
    wait_for(3'd4, 2, "arst_T4");
    chk("arst_pre_acc", acc, 8'h05);
    #1 rst = 1;
    #1;
    chk("arst_state", state, 3'd0);
    chk("arst_acc", acc, 8'h00);
    chk("arst_pc", pc, 4'h0);
    chk("arst_outv", out_valid, 1'b0);
    chk("arst_out", out_data, 8'h00);
    @(negedge clk);
    rst = 0; run = 0;
    m_reset();

    // Random programs, random load-port noise.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int a = 0; a < 16; a++) load_word(a, 8'($urandom));
      exec(25, it[0]);
      leave_halt();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sap_cpu_param.md
Name: sap_cpu_param

Overview:
- Parametrised successor to the SAP-1 CPU top: a single-clock accumulator machine with internal RAM.
- Generalised data/address width; extended instruction set (STA, LDI, JMP, JC, JZ).
- Carry/zero flags; variable-length instruction cycles (4–6 T-states, early return to T1).
- Program load port and run/pause control; sits under the system top as the execution core driving the display.

Parameters:
- DW, 8, data and instruction width.
- AW, 4, address width; RAM depth 2**AW words; opcode width OPW = DW-AW (must be ≥4, elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- run  input  1  1 = execute; 0 = stop at next instruction boundary.
- prog_we  input  1  RAM write strobe; honoured only in IDLE.
- prog_addr  input  AW  RAM load address.
- prog_data  input  DW  RAM load data.
- out_data  output  DW  output register (OUT instruction).
- out_valid  output  1  one-cycle pulse when out_data updates.
- halted  output  1  high in HALT state.
- acc  output  DW  accumulator.
- pc  output  AW  program counter.
- flags  output  2  {C,Z}.
- state  output  3  0 IDLE, 1..6 T1..T6, 7 HALT.

Behaviour:
- Reset (async): acc, B, pc, MAR, IR, flags, out_data = 0; out_valid = 0; halted = 0; state = IDLE. RAM contents are not cleared.
- Instruction format: opcode = instr[DW-1:AW], operand = instr[AW-1:0]. Opcodes use the low 4 bits of the opcode field; upper opcode bits must be 0, else NOP.
- IDLE:
  - prog_we writes RAM[prog_addr] <= prog_data.
  - run=1 -> T1 next cycle; pc is retained, so execution resumes where it stopped.
- Fetch:
  - T1: MAR <= pc.
  - T2: pc <= pc+1 (wraps 2**AW-1 -> 0).
  - T3: IR <= RAM[MAR].
- Execute:
  - 0 LDA: T4 MAR <= operand; T5 acc <= RAM[MAR].
  - 1 ADD / 2 SUB: T4 MAR <= operand; T5 B <= RAM[MAR]; T6 acc <= acc±B (mod 2**DW), flags updated.
  - 3 STA: T4 MAR <= operand; T5 RAM[MAR] <= acc.
  - 4 LDI: T4 acc <= zero-extended operand.
  - 5 JMP: T4 pc <= operand.
  - 6 JC / 7 JZ: T4 pc <= operand iff C / Z; otherwise no change.
  - 14 OUT: T4 out_data <= acc; out_valid high for the following cycle only.
  - 15 HLT: T4 -> HALT.
  - Others: NOP, ending after T4.
- Instruction lengths: 4 cycles for LDI/JMP/JC/JZ/OUT/NOP, 5 for LDA/STA, 6 for ADD/SUB.
- Boundary rule: after the last T-state, next state is T1 if run=1, else IDLE.
- Flags:
  - Only ADD/SUB update them.
  - ADD: C = carry out of bit DW-1.
  - SUB: C = 1 iff acc ≥ B (no borrow).
  - Z = (result == 0).
  - Flags hold through all other instructions.
- HALT: halted=1, all registers hold, prog_we ignored. Exits to IDLE (halted=0) only when run=0; a later run=1 resumes at the pc following HLT.
- prog_we outside IDLE is ignored; no RAM corruption.
- run dropping mid-instruction: the current instruction completes, then the core goes to IDLE.
- rst mid-instruction: immediate return to reset values; partial results are discarded. A STA write completes only if T5 clocked before rst asserted.
- Single RAM port is time-shared: T5 STA write and T3/T5 reads never collide; the load port is active only in IDLE.

Test Plan:
- Basic program, load then run:
  - Program: RAM[0]=0x09, [1]=0x1A, [2]=0xE0, [3]=0xF0, [9]=0x10, [A]=0x14.
  - Required: out_data=0x24 with exactly one out_valid pulse; halted asserts 19 cycles after first T1; acc=0x24, flags C=0 Z=0.
- Overflow/flags:
  - ADD with 0xF0+0x20 -> acc=0x10, C=1, Z=0.
  - SUB 0x10-0x10 -> acc=0x00, C=1, Z=1.
  - SUB 0x05-0x07 -> acc=0xFE, C=0, Z=0.
- Loop with JZ/JMP:
  - LDI 3, then repeat SUB of a word holding 1, OUT, JZ to HLT, JMP to loop.
  - Required: out_data sequence 2,1,0, then halted; pc wrap checked by placing JMP at address 0xF.
- STA/LDI:
  - LDI 5, STA 0xC, LDA 0xC, OUT -> out_data=0x05.
  - Verify via IDLE readback that RAM[0xC]=0x05; prog_we asserted while running leaves RAM unchanged.
- Control:
  - run=0 during T5 of ADD -> ADD completes (acc updated in T6), state=IDLE, pc held.
  - run=1 -> resumes at next instruction.
  - rst pulse in T4 -> all outputs 0 asynchronously before the next clk edge.
- Parametrisation: DW=12, AW=6 -> program at address 0x3F with JMP wrap, ADD 0xFFF+0x001 -> acc=0x000, C=1, Z=1.
